id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised instruction-decode stage for the tinyMIPS pipeline that replaces the combinational decoder with a registered ID/EX boundary. It decodes logic, shift, immediate, load and hint instructions, resolves operands through N prioritised forwarding ports, and detects load-use hazards. It stalls upstream and emits a bubble while a hazard is open. It sits between the IF/ID register and EX, and talks to both over valid/ready handshakes.

## Interface
- DATA_W, 32, register and operand width
- ADDR_W, 32, PC width
- RADDR_W, 5, register-file address width
- FWD_SRCS, 2, number of forwarding ports; index 0 has highest priority (youngest stage)
- STALL_CNT_W, 16, width of the stall-cycle counter
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- pc_i  in  ADDR_W  instruction PC
- inst_i  in  32  instruction word
- flush_i  in  1  discard the registered and incoming instruction
- reg1_addr_o, reg2_addr_o  out  RADDR_W  register-file read addresses (rs, rt), combinational
- reg1_data_i, reg2_data_i  in  DATA_W  register-file read data
- fwd_valid_i  in  FWD_SRCS  forwarding source writes a register
- fwd_addr_i  in  FWD_SRCS*RADDR_W  forwarding destination addresses; port k occupies bits [k*RADDR_W +: RADDR_W]
- fwd_data_i  in  FWD_SRCS*DATA_W  forwarding data; port k occupies bits [k*DATA_W +: DATA_W]
- ex_load_i  in  1  instruction currently in EX is a load
- ex_load_wd_i  in  RADDR_W  destination register of that load
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts the registered instruction
- aluop_o  out  8  ALU operation (EXE_*_OP codes)
- alusel_o  out  3  result select (EXE_RES_* codes)
- reg1_o, reg2_o  out  DATA_W  resolved operands
- wd_o  out  RADDR_W  destination register
- wreg_o  out  1  write-back enable
- is_load_o  out  1  instruction is LW
- pc_o  out  ADDR_W  registered PC
- inst_invalid_o  out  1  unrecognised opcode
- stall_cnt_o  out  STALL_CNT_W  count of load-use stall cycles

## Operation
- Decoded opcodes:
  - R-type (funct field): OR, AND, XOR, NOR, SLLV, SRLV, SRAV, SLL, SRL, SRA, SYNC
  - I-type: ORI, ANDI, XORI, LUI, LW, PREF
- SLL, SRL and SRA require inst[25:21]==0. Their reg1 operand is the zero-extended shamt inst[10:6]; reg2 is rt.
- ORI, ANDI and XORI: reg2 is the zero-extended immediate; wd is rt.
- LUI: reg1 is 0, reg2 is {imm,16'h0}, aluop is OR; wd is rt.
- LW: reg1 is rs, reg2 is the sign-extended immediate, aluop is ADD; is_load=1, wd=rt.
- wreg_o=1 for every register-writing instruction whose wd≠0. SYNC and PREF produce wreg=0 and aluop NOP.
- Unrecognised opcodes decode as NOP with wreg=0 and inst_invalid=1. The instruction is still passed downstream.
- Operand resolution, applied per read port in this order:
  1. If the port is not read, the operand is the immediate or 0.
  2. If the read address is 0, the operand is 0; forwarding is never applied to register 0.
  3. Otherwise, the lowest k with fwd_valid_i[k] and a matching fwd_addr selects fwd_data k.
  4. Otherwise, the operand is the register-file data.
- Hazard condition: in_valid & ex_load_i & ex_load_wd_i≠0 & ((reg1 read & rs==ex_load_wd_i) | (reg2 read & rt==ex_load_wd_i)).
- in_ready = ~flush_i & ~hazard & (~out_valid | out_ready).
- Register update priority, highest first:
  1. Flush: out_valid←0.
  2. Capture (in_valid & in_ready): load all outputs, out_valid←1.
  3. Hazard with the slot free (~out_valid | out_ready): out_valid←0 (bubble).
  4. Otherwise the registers hold.
- stall_cnt_o increments once per cycle in which the hazard is asserted and flush_i=0. It saturates at all-ones and is never cleared except by reset.

## Timing
- Reset (rst_n=0 at a clk edge): out_valid=0, all data outputs=0, aluop=EXE_NOP_OP, alusel=EXE_RES_NOP, stall_cnt=0. in_ready=0 while rst_n=0.
- Latency: an instruction accepted on edge n appears on the outputs after edge n, with out_valid=1.
- Registered outputs are stable while out_valid & ~out_ready; the upstream handshake has no combinational dependency on the outputs except through out_ready.
- A load-use hazard costs exactly one bubble. The load advances out of EX, ex_load_i drops, and the dependent instruction is accepted the next cycle, taking its operand from forwarding port 1 (MEM).
- Flush asserted mid-stall: the bubble and out_valid are cleared, the stall counter does not increment, and in_ready=0 for that cycle.
- Hazard together with out_valid & ~out_ready: hold the registers. The stall cycle is still counted.

## Test plan
- Reset with garbage on the inputs -> out_valid=0, aluop=NOP, all outputs 0, stall_cnt=0; after release, in_ready=1.
- ORI $1,$0,0x1234 -> one cycle later: reg1=0, reg2=0x00001234, wd=1, wreg=1, alusel=LOGIC.
- OR $3,$1,$2 with fwd port0={1,$1,0xAAAA} and port1={1,$1,0x5555} -> reg1=0xAAAA; reg2=reg2_data_i.
- ex_load_i=1, ex_load_wd_i=2, in=OR $3,$2,$4 -> in_ready=0 and one bubble (out_valid=0); stall_cnt becomes 1. Next cycle the instruction is accepted using port 1 data.
- out_ready=0 for 3 cycles -> outputs unchanged and in_ready=0; a flush then clears out_valid.
- Instruction with $0 as destination, and an instruction reading $0 while a forward to $0 is offered -> wreg=0 and operand=0.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
//   Handshake bundle around the registered ID stage: the upstream IF/ID side
//   (in_valid/in_ready + PC/instruction) and the downstream ID/EX side
//   (out_valid/out_ready + decoded payload).
//   slave  : view taken by id_stage_pipe
//   master : view taken by the surrounding pipeline (IF/ID driver + EX sink)
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
);
  // IF/ID -> ID
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  pc_i;
  logic [31:0]        inst_i;
  // ID -> EX
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         aluop_o;
  logic [2:0]         alusel_o;
  logic [DATA_W-1:0]  reg1_o;
  logic [DATA_W-1:0]  reg2_o;
  logic [RADDR_W-1:0] wd_o;
  logic               wreg_o;
  logic               is_load_o;
  logic [ADDR_W-1:0]  pc_o;
  logic               inst_invalid_o;

  modport slave (
    input  in_valid, pc_i, inst_i, out_ready,
    output in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, is_load_o, pc_o, inst_invalid_o
  );

  modport master (
    output in_valid, pc_i, inst_i, out_ready,
    input  in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, is_load_o, pc_o, inst_invalid_o
  );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
//   Registered instruction-decode stage for tinyMIPS. Decodes logic, shift,
//   immediate, load and hint instructions, resolves both operands through
//   FWD_SRCS prioritised forwarding ports (port 0 = youngest), detects
//   load-use hazards against the load in EX and inserts one bubble while the
//   hazard is open.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   bus (slave)         upstream/downstream handshakes + decoded payload
//   flush_i             drop the registered and the incoming instruction
//   reg1/2_addr_o       register-file read addresses (rs, rt), combinational
//   reg1/2_data_i       register-file read data
//   fwd_valid/addr/data forwarding ports, port k in slice k
//   ex_load_i/_wd_i     EX holds a load writing ex_load_wd_i
//   stall_cnt_o         saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int FWD_SRCS    = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  id_stage_pipe_if.slave              bus,
  input  logic                        flush_i,
  output logic [RADDR_W-1:0]          reg1_addr_o,
  output logic [RADDR_W-1:0]          reg2_addr_o,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [FWD_SRCS-1:0]         fwd_valid_i,
  input  logic [FWD_SRCS*RADDR_W-1:0] fwd_addr_i,
  input  logic [FWD_SRCS*DATA_W-1:0]  fwd_data_i,
  input  logic                        ex_load_i,
  input  logic [RADDR_W-1:0]          ex_load_wd_i,
  output logic [STALL_CNT_W-1:0]      stall_cnt_o
);

  // ALU operation codes
  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;

  // Result select codes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_PREF    = 6'b110011;

  // SPECIAL funct codes
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SYNC = 6'b001111;

  // ID/EX payload
  typedef struct packed {
    logic [7:0]         aluop;
    logic [2:0]         alusel;
    logic [DATA_W-1:0]  reg1;
    logic [DATA_W-1:0]  reg2;
    logic [RADDR_W-1:0] wd;
    logic               wreg;
    logic               is_load;
    logic               invalid;
    logic [ADDR_W-1:0]  pc;
  } idex_t;

  // ---------------------------------------------------------------- fields
  logic [31:0]        inst;
  logic [5:0]         op, funct;
  logic [RADDR_W-1:0] rs, rt, rd;
  logic [4:0]         shamt;
  logic [15:0]        imm;

  assign inst  = bus.inst_i;
  assign op    = inst[31:26];
  assign rs    = RADDR_W'(inst[25:21]);
  assign rt    = RADDR_W'(inst[20:16]);
  assign rd    = RADDR_W'(inst[15:11]);
  assign shamt = inst[10:6];
  assign funct = inst[5:0];
  assign imm   = inst[15:0];

  assign reg1_addr_o = rs;
  assign reg2_addr_o = rt;

  // ---------------------------------------------------------------- decode
  logic               rd1, rd2;       // port actually read
  logic [DATA_W-1:0]  imm1, imm2;     // operand used when the port is not read
  logic [7:0]         dec_aluop;
  logic [2:0]         dec_alusel;
  logic [RADDR_W-1:0] dec_wd;
  logic               dec_wr, dec_ld, dec_inv;

  always_comb begin
    rd1        = 1'b0;
    rd2        = 1'b0;
    imm1       = '0;
    imm2       = '0;
    dec_aluop  = EXE_NOP_OP;
    dec_alusel = EXE_RES_NOP;
    dec_wd     = '0;
    dec_wr     = 1'b0;
    dec_ld     = 1'b0;
    dec_inv    = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_OR, F_AND, F_XOR, F_NOR: begin
            rd1        = 1'b1;
            rd2        = 1'b1;
            dec_alusel = EXE_RES_LOGIC;
            dec_wd     = rd;
            dec_wr     = 1'b1;
            case (funct)
              F_OR:    dec_aluop = EXE_OR_OP;
              F_AND:   dec_aluop = EXE_AND_OP;
              F_XOR:   dec_aluop = EXE_XOR_OP;
              default: dec_aluop = EXE_NOR_OP;
            endcase
          end
          // Variable shifts: amount comes from rs, value from rt.
          F_SLLV, F_SRLV, F_SRAV: begin
            rd1        = 1'b1;
            rd2        = 1'b1;
            dec_alusel = EXE_RES_SHIFT;
            dec_wd     = rd;
            dec_wr     = 1'b1;
            case (funct)
              F_SLLV:  dec_aluop = EXE_SLL_OP;
              F_SRLV:  dec_aluop = EXE_SRL_OP;
              default: dec_aluop = EXE_SRA_OP;
            endcase
          end
          // Immediate shifts: the rs field must be zero; shamt rides on reg1.
          F_SLL, F_SRL, F_SRA: begin
            if (inst[25:21] == 5'd0) begin
              rd2        = 1'b1;
              imm1       = DATA_W'(shamt);
              dec_alusel = EXE_RES_SHIFT;
              dec_wd     = rd;
              dec_wr     = 1'b1;
              case (funct)
                F_SLL:   dec_aluop = EXE_SLL_OP;
                F_SRL:   dec_aluop = EXE_SRL_OP;
                default: dec_aluop = EXE_SRA_OP;
              endcase
            end else begin
              dec_inv = 1'b1;
            end
          end
          F_SYNC:  ;
          default: dec_inv = 1'b1;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        rd1        = 1'b1;
        imm2       = DATA_W'(imm);
        dec_alusel = EXE_RES_LOGIC;
        dec_wd     = rt;
        dec_wr     = 1'b1;
        case (op)
          OP_ORI:  dec_aluop = EXE_OR_OP;
          OP_ANDI: dec_aluop = EXE_AND_OP;
          default: dec_aluop = EXE_XOR_OP;
        endcase
      end
      // LUI is OR of zero with the shifted immediate.
      OP_LUI: begin
        imm2       = DATA_W'({imm, 16'h0000});
        dec_aluop  = EXE_OR_OP;
        dec_alusel = EXE_RES_LOGIC;
        dec_wd     = rt;
        dec_wr     = 1'b1;
      end
      // LW: EX computes the address rs + sext(imm).
      OP_LW: begin
        rd1        = 1'b1;
        imm2       = DATA_W'($signed(imm));
        dec_aluop  = EXE_ADD_OP;
        dec_alusel = EXE_RES_ARITH;
        dec_wd     = rt;
        dec_wr     = 1'b1;
        dec_ld     = 1'b1;
      end
      OP_PREF: ;
      default: dec_inv = 1'b1;
    endcase
  end

  // ------------------------------------------------------- operand resolve
  // Walk ports from lowest priority to highest so the lowest matching index
  // wins. Register 0 is hard-wired and never forwarded.
  function automatic logic [DATA_W-1:0] resolve(
    input logic                        rd_en,
    input logic [RADDR_W-1:0]          addr,
    input logic [DATA_W-1:0]           rf_data,
    input logic [DATA_W-1:0]           imm_val,
    input logic [FWD_SRCS-1:0]         fv,
    input logic [FWD_SRCS*RADDR_W-1:0] fa,
    input logic [FWD_SRCS*DATA_W-1:0]  fd
  );
    logic [DATA_W-1:0] r;
    r = rf_data;
    for (int k = FWD_SRCS - 1; k >= 0; k--)
      if (fv[k] && (fa[k*RADDR_W +: RADDR_W] == addr))
        r = fd[k*DATA_W +: DATA_W];
    if (!rd_en)          r = imm_val;
    else if (addr == '0) r = '0;
    return r;
  endfunction

  idex_t dec;

  always_comb begin
    dec         = '0;
    dec.aluop   = dec_aluop;
    dec.alusel  = dec_alusel;
    dec.reg1    = resolve(rd1, rs, reg1_data_i, imm1, fwd_valid_i, fwd_addr_i, fwd_data_i);
    dec.reg2    = resolve(rd2, rt, reg2_data_i, imm2, fwd_valid_i, fwd_addr_i, fwd_data_i);
    dec.wd      = dec_wd;
    dec.wreg    = dec_wr && (dec_wd != '0);
    dec.is_load = dec_ld;
    dec.invalid = dec_inv;
    dec.pc      = bus.pc_i;
  end

  // ------------------------------------------------------- hazard / control
  idex_t                  idex_q, idex_d;
  logic                   vld_q, vld_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   hazard, slot_free, accept;

  assign hazard = bus.in_valid && ex_load_i && (ex_load_wd_i != '0) &&
                  ((rd1 && (rs == ex_load_wd_i)) || (rd2 && (rt == ex_load_wd_i)));

  assign slot_free    = !vld_q || bus.out_ready;
  assign bus.in_ready = rst_n && !flush_i && !hazard && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    vld_d   = vld_q;
    idex_d  = idex_q;
    stall_d = stall_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (accept) begin
      vld_d  = 1'b1;
      idex_d = dec;
    end else if (slot_free) begin
      // Nothing captured while the slot empties: either the hazard bubble or
      // EX consuming the last instruction. Payload holds, valid drops.
      vld_d = 1'b0;
    end
    if (hazard && !flush_i && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      idex_q  <= '0;
      stall_q <= '0;
    end else begin
      vld_q   <= vld_d;
      idex_q  <= idex_d;
      stall_q <= stall_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.out_valid      = vld_q;
  assign bus.aluop_o        = idex_q.aluop;
  assign bus.alusel_o       = idex_q.alusel;
  assign bus.reg1_o         = idex_q.reg1;
  assign bus.reg2_o         = idex_q.reg2;
  assign bus.wd_o           = idex_q.wd;
  assign bus.wreg_o         = idex_q.wreg;
  assign bus.is_load_o      = idex_q.is_load;
  assign bus.pc_o           = idex_q.pc;
  assign bus.inst_invalid_o = idex_q.invalid;
  assign stall_cnt_o        = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;
  localparam int DATA_W = 32, ADDR_W = 32, RADDR_W = 5, FWD_SRCS = 2, SCW = 16;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        flush_i;
  logic [RADDR_W-1:0]          reg1_addr_o, reg2_addr_o;
  logic [DATA_W-1:0]           reg1_data_i, reg2_data_i;
  logic [FWD_SRCS-1:0]         fwd_valid_i;
  logic [FWD_SRCS*RADDR_W-1:0] fwd_addr_i;
  logic [FWD_SRCS*DATA_W-1:0]  fwd_data_i;
  logic                        ex_load_i;
  logic [RADDR_W-1:0]          ex_load_wd_i;
  logic [SCW-1:0]              stall_cnt_o;

  int checks   = 0;
  int failures = 0;

  id_stage_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RADDR_W(RADDR_W)) bus ();

  id_stage_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RADDR_W(RADDR_W),
    .FWD_SRCS(FWD_SRCS), .STALL_CNT_W(SCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flush_i      (flush_i),
    .reg1_addr_o  (reg1_addr_o),
    .reg2_addr_o  (reg2_addr_o),
    .reg1_data_i  (reg1_data_i),
    .reg2_data_i  (reg2_data_i),
    .fwd_valid_i  (fwd_valid_i),
    .fwd_addr_i   (fwd_addr_i),
    .fwd_data_i   (fwd_data_i),
    .ex_load_i    (ex_load_i),
    .ex_load_wd_i (ex_load_wd_i),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset with garbage on the inputs
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.pc_i     = 32'hFFFF_0000;
    bus.inst_i   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    flush_i      = 1'b0;
    reg1_data_i  = 32'h1234_5678;
    reg2_data_i  = 32'h9ABC_DEF0;
    fwd_valid_i  = 2'b11;
    fwd_addr_i   = {5'd7, 5'd3};
    fwd_data_i   = {32'hA5A5_A5A5, 32'h5A5A_5A5A};
    ex_load_i    = 1'b1;
    ex_load_wd_i = 5'd9;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_aluop",     64'(bus.aluop_o),   64'h00);
    chk("rst_alusel",    64'(bus.alusel_o),  64'd0);
    chk("rst_reg1",      64'(bus.reg1_o),    64'd0);
    chk("rst_reg2",      64'(bus.reg2_o),    64'd0);
    chk("rst_wd_wreg",   64'({bus.wd_o, bus.wreg_o, bus.is_load_o, bus.inst_invalid_o}), 64'd0);
    chk("rst_pc",        64'(bus.pc_o),      64'd0);
    chk("rst_stall",     64'(stall_cnt_o),   64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);

    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    fwd_valid_i  = 2'b00;
    ex_load_i    = 1'b0;
    ex_load_wd_i = 5'd0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // ---------------- ORI $1,$0,0x1234
    bus.in_valid = 1'b1;
    bus.pc_i     = 32'h0000_0100;
    bus.inst_i   = itype(6'h0d, 5'd0, 5'd1, 16'h1234);
    tick();
    chk("ori_valid",  64'(bus.out_valid), 64'd1);
    chk("ori_reg1",   64'(bus.reg1_o),    64'd0);
    chk("ori_reg2",   64'(bus.reg2_o),    64'h0000_1234);
    chk("ori_wd",     64'(bus.wd_o),      64'd1);
    chk("ori_wreg",   64'(bus.wreg_o),    64'd1);
    chk("ori_alusel", 64'(bus.alusel_o),  64'd1);
    chk("ori_aluop",  64'(bus.aluop_o),   64'h25);
    chk("ori_pc",     64'(bus.pc_o),      64'h100);

    // ---------------- OR $3,$1,$2 with both ports forwarding $1
    bus.pc_i    = 32'h0000_0104;
    bus.inst_i  = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
    reg1_data_i = 32'h1111_1111;
    reg2_data_i = 32'h2222_2222;
    fwd_valid_i = 2'b11;
    fwd_addr_i  = {5'd1, 5'd1};
    fwd_data_i  = {32'h0000_5555, 32'h0000_AAAA};
    #1;
    chk("or_raddr", 64'({reg1_addr_o, reg2_addr_o}), 64'({5'd1, 5'd2}));
    tick();
    chk("or_reg1_fwd0", 64'(bus.reg1_o), 64'h0000_AAAA);
    chk("or_reg2_rf",   64'(bus.reg2_o), 64'h2222_2222);
    chk("or_wd",        64'(bus.wd_o),   64'd3);

    // ---------------- load-use hazard: OR $3,$2,$4 behind LW $2
    bus.pc_i     = 32'h0000_0108;
    bus.inst_i   = rtype(5'd2, 5'd4, 5'd3, 5'd0, 6'h25);
    fwd_valid_i  = 2'b00;
    ex_load_i    = 1'b1;
    ex_load_wd_i = 5'd2;
    #1;
    chk("haz_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("haz_bubble", 64'(bus.out_valid), 64'd0);
    chk("haz_stall1", 64'(stall_cnt_o),   64'd1);
    ex_load_i   = 1'b0;
    fwd_valid_i = 2'b10;
    fwd_addr_i  = {5'd2, 5'd0};
    fwd_data_i  = {32'hCAFE_0000, 32'h0000_0000};
    reg2_data_i = 32'h0000_0044;
    #1;
    chk("haz_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("haz_accept_valid", 64'(bus.out_valid), 64'd1);
    chk("haz_reg1_fwd1",    64'(bus.reg1_o),    64'hCAFE_0000);
    chk("haz_reg2_rf",      64'(bus.reg2_o),    64'h0000_0044);

    // ---------------- backpressure for 3 cycles, then flush
    bus.out_ready = 1'b0;
    bus.pc_i      = 32'h0000_010C;
    bus.inst_i    = itype(6'h0e, 5'd1, 5'd2, 16'h00FF);
    fwd_valid_i   = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold_reg1",  64'(bus.reg1_o),    64'hCAFE_0000);
      chk("bp_hold_pc",    64'(bus.pc_o),      64'h108);
    end
    flush_i = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);

    // ---------------- flush during an open hazard: no count, stays empty
    bus.out_ready = 1'b1;
    ex_load_i     = 1'b1;
    ex_load_wd_i  = 5'd1;
    tick();
    chk("flush_haz_stall", 64'(stall_cnt_o),   64'd1);
    chk("flush_haz_valid", 64'(bus.out_valid), 64'd0);
    flush_i   = 1'b0;
    ex_load_i = 1'b0;

    // ---------------- ORI $0,$1,5 : destination $0
    bus.inst_i  = itype(6'h0d, 5'd1, 5'd0, 16'h0005);
    reg1_data_i = 32'h0000_0007;
    tick();
    chk("zdst_valid", 64'(bus.out_valid), 64'd1);
    chk("zdst_wreg",  64'({bus.wd_o, bus.wreg_o}), 64'd0);
    chk("zdst_reg1",  64'(bus.reg1_o), 64'h7);

    // ---------------- OR $5,$0,$0 with a forward to $0 offered
    bus.inst_i  = rtype(5'd0, 5'd0, 5'd5, 5'd0, 6'h25);
    reg1_data_i = 32'h0000_0011;
    reg2_data_i = 32'h0000_0022;
    fwd_valid_i = 2'b01;
    fwd_addr_i  = {5'd0, 5'd0};
    fwd_data_i  = {32'h0, 32'h0000_DEAD};
    tick();
    chk("zsrc_reg1", 64'(bus.reg1_o), 64'd0);
    chk("zsrc_reg2", 64'(bus.reg2_o), 64'd0);
    chk("zsrc_wreg", 64'({bus.wd_o, bus.wreg_o}), 64'({5'd5, 1'b1}));

    // ---------------- LW $6,-4($1)
    fwd_valid_i = 2'b00;
    bus.inst_i  = itype(6'h23, 5'd1, 5'd6, 16'hFFFC);
    reg1_data_i = 32'h0000_1000;
    tick();
    chk("lw_reg1",  64'(bus.reg1_o), 64'h0000_1000);
    chk("lw_reg2",  64'(bus.reg2_o), 64'hFFFF_FFFC);
    chk("lw_ctrl",  64'({bus.aluop_o, bus.alusel_o, bus.is_load_o, bus.wreg_o, bus.wd_o}),
                    64'({8'h20, 3'd4, 1'b1, 1'b1, 5'd6}));

    // ---------------- LUI $7,0xBEEF
    bus.inst_i = itype(6'h0f, 5'd3, 5'd7, 16'hBEEF);
    tick();
    chk("lui_ops",  64'({bus.reg1_o, bus.reg2_o}), {32'h0, 32'hBEEF_0000});
    chk("lui_ctrl", 64'({bus.aluop_o, bus.alusel_o, bus.is_load_o, bus.wd_o}),
                    64'({8'h25, 3'd1, 1'b0, 5'd7}));

    // ---------------- SLL $8,$9,4
    bus.inst_i  = rtype(5'd0, 5'd9, 5'd8, 5'd4, 6'h00);
    reg2_data_i = 32'h0000_0022;
    tick();
    chk("sll_ops",  64'({bus.reg1_o, bus.reg2_o}), {32'h4, 32'h22});
    chk("sll_ctrl", 64'({bus.aluop_o, bus.alusel_o, bus.wreg_o, bus.wd_o}),
                    64'({8'h7c, 3'd2, 1'b1, 5'd8}));

    // ---------------- unrecognised opcode
    bus.inst_i = 32'hFC00_0000;
    tick();
    chk("inv_flags", 64'({bus.out_valid, bus.inst_invalid_o, bus.wreg_o, bus.aluop_o}),
                     64'({1'b1, 1'b1, 1'b0, 8'h00}));

    // ---------------- SYNC
    bus.inst_i = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h0f);
    tick();
    chk("sync_flags", 64'({bus.inst_invalid_o, bus.wreg_o, bus.aluop_o}),
                      64'({1'b0, 1'b0, 8'h00}));

    // ---------------- drain
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("final_stall", 64'(stall_cnt_o),   64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
